// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between an SPI master and the register-file responder.
// Latency: wires only, no storage.
// Backpressure: none; the master paces every bit with SCLK.
interface spi_slave_regfile_if;
  logic spi_sclk;
  logic spi_ss_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport slave (
    input  spi_sclk,
    input  spi_ss_n,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );

  modport master (
    output spi_sclk,
    output spi_ss_n,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder in front of a 32x8 register file with a command/data byte framing.
// Latency: pins reach the core after SYNC_STAGES flops; writes commit on the 8th rise, wr_pulse one cycle later.
// Backpressure: none; the master owns SCLK and the local port is always ready.
module spi_slave_regfile #(
  parameter int NUM_REGS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  spi_slave_regfile_if.slave          spi,
  input  logic [7:0]                  status_in,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  input  logic                        loc_we,
  input  logic [$clog2(NUM_REGS)-1:0] loc_addr,
  input  logic [7:0]                  loc_wdata,
  output logic [7:0]                  loc_rdata,
  output logic                        busy
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sclk_sh;
  logic [SYNC_STAGES-1:0] ss_sh;
  logic [SYNC_STAGES-1:0] mosi_sh;
  logic                   sclk_q;
  logic                   ss_q;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall;
  logic rise_act, fall_act;

  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sh;
  logic [7:0]    rx_byte;
  logic [7:0]    sh_out;
  logic [AW-1:0] cmd_addr;
  logic          cmd_dir;
  logic          load_pend;

  logic start;
  logic byte_done;
  logic spi_we;

  logic [7:0] regs [NUM_REGS];

  // Synchronize the SPI pins into the core clock domain and keep one extra tap for edge detection.
  // The ss_n chain resets low so a select that is already asserted after reset never looks like a
  // fresh falling edge; the master's leftover bits are then ignored until it reselects.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_sh <= '0;
      ss_sh   <= '0;
      mosi_sh <= '0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b0;
    end else begin
      sclk_sh <= {sclk_sh[SYNC_STAGES-2:0], spi.spi_sclk};
      ss_sh   <= {ss_sh[SYNC_STAGES-2:0], spi.spi_ss_n};
      mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], spi.spi_mosi};
      sclk_q  <= sclk_sh[SYNC_STAGES-1];
      ss_q    <= ss_sh[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sh[SYNC_STAGES-1];
  assign ss_s      = ss_sh[SYNC_STAGES-1];
  assign mosi_s    = mosi_sh[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_fall   = ss_q & ~ss_s;

  // SCLK edges only count inside a selected transaction.
  assign rise_act = sclk_rise & ~ss_s & (state != ST_IDLE);
  assign fall_act = sclk_fall & ~ss_s & (state != ST_IDLE);
  assign rx_byte  = {rx_sh, mosi_s};

  // State register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and per-cycle control strobes; deselect aborts from any state.
  always_comb begin
    state_d   = state;
    start     = 1'b0;
    byte_done = 1'b0;
    spi_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_CMD;
          start   = 1'b1;
        end
      end
      ST_CMD: begin
        if (ss_s) begin
          state_d = ST_IDLE;
        end else if (rise_act && bit_cnt == 3'd7) begin
          state_d   = ST_DATA;
          byte_done = 1'b1;
        end
      end
      ST_DATA: begin
        if (ss_s) begin
          state_d = ST_IDLE;
        end else if (rise_act && bit_cnt == 3'd7) begin
          byte_done = 1'b1;
          spi_we    = cmd_dir;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit counter, receive/transmit shifters, command latch and the committed-write strobe.
  // The fall right after a byte's 8th rise is skipped (bit_cnt == 0) so the freshly loaded
  // first bit of the next byte stays on MISO until the master samples it.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      sh_out    <= '0;
      cmd_addr  <= '0;
      cmd_dir   <= 1'b0;
      load_pend <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_pulse  <= 1'b0;
      load_pend <= 1'b0;
      if (start) begin
        sh_out  <= status_in;
        bit_cnt <= '0;
      end
      if (rise_act) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sh   <= rx_byte[6:0];
      end
      if (fall_act && bit_cnt != 3'd0) begin
        sh_out <= {sh_out[6:0], 1'b0};
      end
      if (byte_done && state == ST_CMD) begin
        cmd_addr <= rx_byte[7 -: AW];
        cmd_dir  <= rx_byte[1];
        if (rx_byte[1]) begin
          sh_out <= '0;
        end else begin
          load_pend <= 1'b1;
        end
      end
      if (byte_done && state == ST_DATA && !cmd_dir) begin
        load_pend <= 1'b1;
      end
      if (spi_we) begin
        wr_pulse <= 1'b1;
        wr_addr  <= cmd_addr;
        wr_data  <= rx_byte;
      end
      // Read data is fetched one cycle after the boundary so a just-latched address is used.
      if (load_pend) begin
        sh_out <= regs[cmd_addr];
      end
    end
  end

  // Register file: local write first, SPI write last so the SPI side wins a same-address collision.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (loc_we) begin
        regs[loc_addr] <= loc_wdata;
      end
      if (spi_we) begin
        regs[cmd_addr] <= rx_byte;
      end
    end
  end

  // Registered local read port.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      loc_rdata <= '0;
    end else begin
      loc_rdata <= regs[loc_addr];
    end
  end

  // MISO is only driven while a transaction is open; leaving it drops data and enable together.
  assign busy            = (state != ST_IDLE);
  assign spi.spi_miso_oe = busy;
  assign spi.spi_miso    = busy & sh_out[7];

endmodule

// File: tb/tb_spi_slave_regfile.sv
module tb_spi_slave_regfile;
  localparam int NUM_REGS    = 32;
  localparam int SYNC_STAGES = 2;

  logic       clk_clk     = 1'b0;
  logic       reset_reset = 1'b1;
  logic [7:0] status_in   = 8'h00;
  logic       wr_pulse;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       loc_we      = 1'b0;
  logic [4:0] loc_addr    = 5'd0;
  logic [7:0] loc_wdata   = 8'h00;
  logic [7:0] loc_rdata;
  logic       busy;

  spi_slave_regfile_if spi();

  spi_slave_regfile #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .spi         (spi),
    .status_in   (status_in),
    .wr_pulse    (wr_pulse),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .loc_we      (loc_we),
    .loc_addr    (loc_addr),
    .loc_wdata   (loc_wdata),
    .loc_rdata   (loc_rdata),
    .busy        (busy)
  );

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad   = 0;

  // Every committed write seen on the strobe, as {addr, data}.
  logic [12:0] pq [$];
  always @(negedge clk_clk) begin
    if (wr_pulse === 1'b1) pq.push_back({wr_addr, wr_data});
  end

  // Reference register contents.
  logic [7:0] mregs [NUM_REGS];

  typedef struct {
    logic            pre_we;
    logic [4:0]      pre_addr;
    logic [7:0]      pre_data;
    logic [7:0]      cmd;
    int              nb;
    logic [3:0][7:0] dat;
    logic [4:0][7:0] exp_miso;
    int              exp_np;
    logic [4:0]      chk_addr;
    logic [7:0]      chk_val;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic local_write(input logic [4:0] a, input logic [7:0] d);
    loc_addr  = a;
    loc_wdata = d;
    loc_we    = 1'b1;
    @(negedge clk_clk);
    loc_we    = 1'b0;
    mregs[a]  = d;
  endtask

  task automatic loc_read(input logic [4:0] a, output logic [7:0] d);
    loc_addr = a;
    @(negedge clk_clk);
    @(negedge clk_clk);
    d = loc_rdata;
  endtask

  // One byte (or its first nbits) at SCLK = clk/10; optional local write timed onto the 8th rise commit.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input logic coll,
                          input logic [4:0] ca, input logic [7:0] cd, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi.spi_mosi = tx[7-i];
      repeat (5) @(negedge clk_clk);
      rx[7-i] = spi.spi_miso;
      spi.spi_sclk = 1'b1;
      if (coll && i == 7) begin
        repeat (SYNC_STAGES) @(negedge clk_clk);
        loc_addr  = ca;
        loc_wdata = cd;
        loc_we    = 1'b1;
        @(negedge clk_clk);
        loc_we    = 1'b0;
        repeat (4 - SYNC_STAGES) @(negedge clk_clk);
      end else begin
        repeat (5) @(negedge clk_clk);
      end
      spi.spi_sclk = 1'b0;
    end
  endtask

  task automatic ss_low();
    spi.spi_ss_n = 1'b0;
    repeat (6) @(negedge clk_clk);
  endtask

  task automatic ss_high();
    repeat (6) @(negedge clk_clk);
    spi.spi_ss_n = 1'b1;
    repeat (8) @(negedge clk_clk);
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input int nb, input logic [3:0][7:0] dat,
                         output logic [4:0][7:0] miso);
    logic [7:0] b;
    miso = '0;
    ss_low();
    spi_byte(cmd, 8, 1'b0, 5'd0, 8'h00, b);
    miso[0] = b;
    for (int k = 0; k < nb; k++) begin
      spi_byte(dat[k], 8, 1'b0, 5'd0, 8'h00, b);
      miso[k+1] = b;
    end
    ss_high();
  endtask

  // Transaction run against the reference: status first, then either the addressed register
  // repeated once per byte (read) or zeros with one committed write per byte (write).
  task automatic model_txn(input string tag, input logic [7:0] cmd, input int nb, input logic [3:0][7:0] dat);
    logic [4:0][7:0] got;
    logic [4:0][7:0] exp;
    logic [12:0]     expq [$];
    logic [4:0]      a;
    a   = cmd[7:3];
    exp = '0;
    exp[0] = status_in;
    for (int k = 0; k < nb; k++) begin
      if (cmd[1]) begin
        exp[k+1] = 8'h00;
        mregs[a] = dat[k];
        expq.push_back({a, dat[k]});
      end else begin
        exp[k+1] = mregs[a];
      end
    end
    pq.delete();
    spi_txn(cmd, nb, dat, got);
    for (int k = 0; k <= nb; k++) chk({tag, "_miso"}, 32'(got[k]), 32'(exp[k]));
    chk({tag, "_npulse"}, 32'(pq.size()), 32'(expq.size()));
    for (int k = 0; k < expq.size() && k < pq.size(); k++) chk({tag, "_pulse"}, 32'(pq[k]), 32'(expq[k]));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_miso"},     32'(spi.spi_miso),    32'h0);
    chk({tag, "_miso_oe"},  32'(spi.spi_miso_oe), 32'h0);
    chk({tag, "_wr_pulse"}, 32'(wr_pulse),        32'h0);
    chk({tag, "_wr_addr"},  32'(wr_addr),         32'h0);
    chk({tag, "_wr_data"},  32'(wr_data),         32'h0);
    chk({tag, "_loc_rdata"},32'(loc_rdata),       32'h0);
    chk({tag, "_busy"},     32'(busy),            32'h0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0][7:0] got;
    logic [7:0]      b, r;
    int              n;

    spi.spi_sclk = 1'b0;
    spi.spi_ss_n = 1'b1;
    spi.spi_mosi = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;

    vecs[0] = '{1'b0, 5'd0,  8'h00, 8'hA2, 1, 32'h0000005C, 40'h0000000081, 1, 5'd20, 8'h5C};
    vecs[1] = '{1'b1, 5'd3,  8'hE7, 8'h18, 2, 32'h00000000, 40'h0000E7E781, 0, 5'd3,  8'hE7};
    vecs[2] = '{1'b0, 5'd0,  8'h00, 8'h3A, 3, 32'h00030201, 40'h0000000081, 3, 5'd7,  8'h03};
    vecs[3] = '{1'b0, 5'd0,  8'h00, 8'hA0, 1, 32'h00000000, 40'h0000005C81, 0, 5'd20, 8'h5C};
    vecs[4] = '{1'b0, 5'd0,  8'h00, 8'h3B, 1, 32'h00000044, 40'h0000000081, 1, 5'd7,  8'h44};
    vecs[5] = '{1'b0, 5'd0,  8'h00, 8'h39, 2, 32'h00000000, 40'h0000444481, 0, 5'd7,  8'h44};
    vecs[6] = '{1'b1, 5'd31, 8'hC3, 8'hF8, 1, 32'h00000000, 40'h000000C381, 0, 5'd31, 8'hC3};

    // Reset state
    repeat (3) @(negedge clk_clk);
    chk_outputs_zero("reset");
    reset_reset = 1'b0;
    repeat (4) @(negedge clk_clk);

    // Directed table
    status_in = 8'h81;
    foreach (vecs[v]) begin
      if (vecs[v].pre_we) local_write(vecs[v].pre_addr, vecs[v].pre_data);
      pq.delete();
      spi_txn(vecs[v].cmd, vecs[v].nb, vecs[v].dat, got);
      for (int k = 0; k <= vecs[v].nb; k++) chk($sformatf("vec%0d_miso%0d", v, k), 32'(got[k]), 32'(vecs[v].exp_miso[k]));
      chk($sformatf("vec%0d_npulse", v), 32'(pq.size()), 32'(vecs[v].exp_np));
      for (int k = 0; k < vecs[v].exp_np && k < pq.size(); k++)
        chk($sformatf("vec%0d_pulse%0d", v, k), 32'(pq[k]), 32'({vecs[v].cmd[7:3], vecs[v].dat[k]}));
      loc_read(vecs[v].chk_addr, r);
      chk($sformatf("vec%0d_readback", v), 32'(r), 32'(vecs[v].chk_val));
    end

    // Collision: same address, SPI write wins
    pq.delete();
    ss_low();
    spi_byte(8'h3A, 8, 1'b0, 5'd0, 8'h00, b);
    spi_byte(8'h11, 8, 1'b1, 5'd7, 8'h99, b);
    ss_high();
    chk("coll_same_npulse", 32'(pq.size()), 32'd1);
    loc_read(5'd7, r);
    chk("coll_same_reg7", 32'(r), 32'h11);

    // Collision: different addresses both commit
    ss_low();
    spi_byte(8'h3A, 8, 1'b0, 5'd0, 8'h00, b);
    spi_byte(8'h11, 8, 1'b1, 5'd8, 8'h99, b);
    ss_high();
    loc_read(5'd7, r);
    chk("coll_diff_reg7", 32'(r), 32'h11);
    loc_read(5'd8, r);
    chk("coll_diff_reg8", 32'(r), 32'h99);

    // Abort after a partial data byte
    local_write(5'd1, 8'h3C);
    pq.delete();
    ss_low();
    spi_byte(8'h0A, 8, 1'b0, 5'd0, 8'h00, b);
    spi_byte(8'hB5, 5, 1'b0, 5'd0, 8'h00, b);
    repeat (3) @(negedge clk_clk);
    chk("abort_oe_before", 32'(spi.spi_miso_oe), 32'h1);
    spi.spi_ss_n = 1'b1;
    n = 11;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_clk);
      if (spi.spi_miso_oe === 1'b0) begin
        n = c;
        break;
      end
    end
    total++;
    if (n > SYNC_STAGES + 1) begin
      bad++;
      $display("FAIL abort_oe_latency: oe dropped after %0d cycles, limit %0d", n, SYNC_STAGES + 1);
    end
    chk("abort_miso", 32'(spi.spi_miso), 32'h0);
    repeat (8) @(negedge clk_clk);
    chk("abort_npulse", 32'(pq.size()), 32'd0);
    loc_read(5'd1, r);
    chk("abort_reg1", 32'(r), 32'h3C);

    // Reset during the 4th data bit of a write
    pq.delete();
    ss_low();
    spi_byte(8'h3A, 8, 1'b0, 5'd0, 8'h00, b);
    spi_byte(8'hC6, 3, 1'b0, 5'd0, 8'h00, b);
    spi.spi_mosi = 1'b0;
    repeat (5) @(negedge clk_clk);
    spi.spi_sclk = 1'b1;
    repeat (2) @(negedge clk_clk);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    chk_outputs_zero("rst_mid");
    reset_reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
    repeat (2) @(negedge clk_clk);
    spi.spi_sclk = 1'b0;
    spi_byte(8'h60, 4, 1'b0, 5'd0, 8'h00, b);
    spi_byte(8'hFF, 8, 1'b0, 5'd0, 8'h00, b);
    ss_high();
    chk("rst_mid_npulse", 32'(pq.size()), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    loc_read(5'd7, r);
    chk("rst_mid_reg7", 32'(r), 32'h00);
    loc_read(5'd20, r);
    chk("rst_mid_reg20", 32'(r), 32'h00);
    loc_read(5'd1, r);
    chk("rst_mid_reg1", 32'(r), 32'h00);
    model_txn("post_rst_wr", 8'h4A, 1, 32'h0000005A);
    model_txn("post_rst_rd", 8'h48, 1, 32'h00000000);

    // Randomized transactions against the reference
    for (int t = 0; t < 20; t++) begin
      logic [7:0]      cmd;
      logic [3:0][7:0] dat;
      int              nb;
      status_in = 8'($urandom);
      if ($urandom_range(0, 1) == 1) local_write(5'($urandom), 8'($urandom));
      cmd = 8'($urandom);
      nb  = $urandom_range(1, 3);
      dat = 32'($urandom);
      model_txn($sformatf("rnd%0d", t), cmd, nb, dat);
      loc_read(cmd[7:3], r);
      chk($sformatf("rnd%0d_readback", t), 32'(r), 32'(mregs[cmd[7:3]]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
